arbiter_requester: RTL

ARBITER_REQUESTER -- requirements
Module: arbiter_requester

---
 rtl/arbiter_requester.sv | 79 +++++++
 1 files changed

// File: rtl/arbiter_requester.sv
// Per-client request front end for a fixed-priority arbiter: pending counters,
// overflow drop, starvation tracking and a sticky grant-protocol error flag.
module arbiter_requester #(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 3,
    parameter int STARVE_LIM = 15
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic [NUM_REQ-1:0]       push_i,
    input  logic [NUM_REQ-1:0]       gnt_i,
    output logic [NUM_REQ-1:0]       req_o,
    output logic [NUM_REQ-1:0]       full_o,
    output logic [NUM_REQ-1:0]       drop_o,
    output logic [NUM_REQ*CNT_W-1:0] pend_cnt_o,
    output logic [NUM_REQ-1:0]       starve_o,
    output logic                     gnt_err_o
);

    localparam int WCW = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [WCW-1:0]     W_LIM   = WCW'(STARVE_LIM);
    localparam logic [WCW-1:0]     W_ONE   = WCW'(1);
    localparam logic [NUM_REQ-1:0] G_ONE   = NUM_REQ'(1);

    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_REQ-1:0][WCW-1:0]   wcnt_q, wcnt_d;
    logic                          gnt_err_q, gnt_err_d;
    logic [NUM_REQ-1:0]            consumed;
    logic [NUM_REQ-1:0]            accept;
    logic                          gnt_multi;

    // All client-facing status comes from registered state; only drop_o sees push_i.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_client
        assign req_o[g]    = (cnt_q[g] != '0);
        assign full_o[g]   = (cnt_q[g] == CNT_MAX);
        assign starve_o[g] = (wcnt_q[g] == W_LIM);
    end

    assign consumed   = gnt_i & req_o;
    assign drop_o     = push_i & full_o & ~consumed;
    assign accept     = push_i & ~drop_o;
    assign pend_cnt_o = cnt_q;
    assign gnt_err_o  = gnt_err_q;
    // x & (x-1) clears the lowest set bit; anything left means more than one grant.
    assign gnt_multi  = |(gnt_i & (gnt_i - G_ONE));

    always_comb begin
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        gnt_err_d = gnt_err_q | gnt_multi | (|(gnt_i & ~req_o));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i] && !consumed[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (consumed[i] && !accept[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
            if (!req_o[i] || consumed[i]) begin
                wcnt_d[i] = '0;
            end else if (wcnt_q[i] != W_LIM) begin
                wcnt_d[i] = wcnt_q[i] + W_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q     <= '0;
            wcnt_q    <= '0;
            gnt_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            gnt_err_q <= gnt_err_d;
        end
    end

endmodule
